// File: rtl/duc_mixer_stream_if.sv
// Sample/LO input stream, mixed output stream and saturation statistics of duc_mixer_stream.
interface duc_mixer_stream_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LO_WIDTH = 18
);
    logic signed [WIDTH-1:0]    i_inph_data;
    logic signed [WIDTH-1:0]    i_quad_data;
    logic signed [LO_WIDTH-1:0] i_cos;
    logic signed [LO_WIDTH-1:0] i_sin;
    logic                       i_valid;
    logic                       o_ready;
    logic [1:0]                 i_mode;
    logic                       i_sat_clear;
    logic signed [WIDTH-1:0]    o_inph_data;
    logic signed [WIDTH-1:0]    o_quad_data;
    logic                       o_valid;
    logic                       i_ready;
    logic [15:0]                o_sat_count;
    logic                       o_sat_flag;

    modport master (
        output i_inph_data, i_quad_data, i_cos, i_sin, i_valid, i_mode, i_sat_clear, i_ready,
        input  o_ready, o_inph_data, o_quad_data, o_valid, o_sat_count, o_sat_flag
    );

    modport slave (
        input  i_inph_data, i_quad_data, i_cos, i_sin, i_valid, i_mode, i_sat_clear, i_ready,
        output o_ready, o_inph_data, o_quad_data, o_valid, o_sat_count, o_sat_flag
    );
endinterface

// File: rtl/duc_mixer_stream.sv
// Complex LO mixer: 4-stage register/multiply/add/round-saturate pipeline with
// global stall on output backpressure and sticky saturation statistics.
module duc_mixer_stream #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LO_WIDTH   = 18,
    parameter int unsigned GAIN_SHIFT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    duc_mixer_stream_if.slave bus
);
    localparam int unsigned PW = WIDTH + LO_WIDTH;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned S  = LO_WIDTH - 1 - GAIN_SHIFT;
    localparam logic signed [SW-1:0] HALF = SW'(64'd1 << (S - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic                       adv;
    logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic signed [WIDTH-1:0]    i1_q, i1_d, q1_q, q1_d;
    logic signed [LO_WIDTH-1:0] cos1_q, cos1_d, sin1_q, sin1_d;
    logic [1:0]                 mode1_q, mode1_d;
    logic signed [PW-1:0]       p_ic_q, p_ic_d, p_qs_q, p_qs_d, p_qc_q, p_qc_d, p_is_q, p_is_d;
    logic                       neg2_q, neg2_d;
    logic signed [SW-1:0]       sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic signed [SW-1:0]       rnd_i, rnd_q;
    logic signed [WIDTH-1:0]    out_i_q, out_i_d, out_q_q, out_q_d;
    logic                       sat4_q, sat4_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       flag_q, flag_d;

    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > MAXV) return WIDTH'(MAXV);
        if (v < MINV) return WIDTH'(MINV);
        return WIDTH'(v);
    endfunction

    assign adv             = !v4_q || bus.i_ready;
    assign bus.o_ready     = adv;
    assign bus.o_valid     = v4_q;
    assign bus.o_inph_data = out_i_q;
    assign bus.o_quad_data = out_q_q;
    assign bus.o_sat_count = cnt_q;
    assign bus.o_sat_flag  = flag_q;

    // Bypass reuses the datapath: I<<S passes rounding unchanged and can never clip.
    always_comb begin
        v1_d    = v1_q;    v2_d    = v2_q;    v3_d    = v3_q;    v4_d    = v4_q;
        i1_d    = i1_q;    q1_d    = q1_q;    cos1_d  = cos1_q;  sin1_d  = sin1_q;
        mode1_d = mode1_q; neg2_d  = neg2_q;
        p_ic_d  = p_ic_q;  p_qs_d  = p_qs_q;  p_qc_d  = p_qc_q;  p_is_d  = p_is_q;
        sum_i_d = sum_i_q; sum_q_d = sum_q_q;
        out_i_d = out_i_q; out_q_d = out_q_q; sat4_d  = sat4_q;
        cnt_d   = cnt_q;   flag_d  = flag_q;
        rnd_i   = (sum_i_q + HALF) >>> S;
        rnd_q   = (sum_q_q + HALF) >>> S;

        if (adv) begin
            v1_d = bus.i_valid;
            if (bus.i_valid) begin
                i1_d    = bus.i_inph_data;
                q1_d    = bus.i_quad_data;
                cos1_d  = bus.i_cos;
                sin1_d  = bus.i_sin;
                mode1_d = bus.i_mode;
            end
            v2_d = v1_q;
            if (v1_q) begin
                neg2_d = (mode1_q == 2'b01);
                if (mode1_q[1]) begin
                    p_ic_d = PW'(i1_q) <<< S;
                    p_qc_d = PW'(q1_q) <<< S;
                    p_qs_d = '0;
                    p_is_d = '0;
                end else begin
                    p_ic_d = PW'(i1_q) * PW'(cos1_q);
                    p_qs_d = PW'(q1_q) * PW'(sin1_q);
                    p_qc_d = PW'(q1_q) * PW'(cos1_q);
                    p_is_d = PW'(i1_q) * PW'(sin1_q);
                end
            end
            v3_d = v2_q;
            if (v2_q) begin
                sum_i_d = neg2_q ? SW'(p_ic_q) + SW'(p_qs_q) : SW'(p_ic_q) - SW'(p_qs_q);
                sum_q_d = neg2_q ? SW'(p_qc_q) - SW'(p_is_q) : SW'(p_qc_q) + SW'(p_is_q);
            end
            v4_d = v3_q;
            if (v3_q) begin
                out_i_d = clamp(rnd_i);
                out_q_d = clamp(rnd_q);
                sat4_d  = (rnd_i > MAXV) || (rnd_i < MINV) || (rnd_q > MAXV) || (rnd_q < MINV);
            end
        end

        // Clear wins over an event landing in the same cycle.
        if (bus.i_sat_clear) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (v4_q && bus.i_ready && sat4_q) begin
            flag_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            v1_q    <= 1'b0; v2_q    <= 1'b0; v3_q    <= 1'b0; v4_q    <= 1'b0;
            i1_q    <= '0;   q1_q    <= '0;   cos1_q  <= '0;   sin1_q  <= '0;
            mode1_q <= '0;   neg2_q  <= 1'b0;
            p_ic_q  <= '0;   p_qs_q  <= '0;   p_qc_q  <= '0;   p_is_q  <= '0;
            sum_i_q <= '0;   sum_q_q <= '0;
            out_i_q <= '0;   out_q_q <= '0;   sat4_q  <= 1'b0;
            cnt_q   <= '0;   flag_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;    v2_q    <= v2_d;    v3_q    <= v3_d;    v4_q    <= v4_d;
            i1_q    <= i1_d;    q1_q    <= q1_d;    cos1_q  <= cos1_d;  sin1_q  <= sin1_d;
            mode1_q <= mode1_d; neg2_q  <= neg2_d;
            p_ic_q  <= p_ic_d;  p_qs_q  <= p_qs_d;  p_qc_q  <= p_qc_d;  p_is_q  <= p_is_d;
            sum_i_q <= sum_i_d; sum_q_q <= sum_q_d;
            out_i_q <= out_i_d; out_q_q <= out_q_d; sat4_q  <= sat4_d;
            cnt_q   <= cnt_d;   flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_duc_mixer_stream.sv
// Directed bench for duc_mixer_stream (WIDTH=16, LO_WIDTH=18, GAIN_SHIFT=0).
module tb_duc_mixer_stream;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned LO_WIDTH = 18;

    typedef struct {
        logic [1:0] mode;
        int         i, q, c, s;
        int         ei, eq;
        bit         sat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   sent;
    int   rcv;
    int   exp_cnt;
    vec_t vt[12];

    duc_mixer_stream_if #(.WIDTH(WIDTH), .LO_WIDTH(LO_WIDTH)) bus ();

    duc_mixer_stream #(.WIDTH(WIDTH), .LO_WIDTH(LO_WIDTH), .GAIN_SHIFT(0)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input int i, input int q, input int c, input int s,
                         input logic v);
        bus.i_mode      = m;
        bus.i_inph_data = WIDTH'(i);
        bus.i_quad_data = WIDTH'(q);
        bus.i_cos       = LO_WIDTH'(c);
        bus.i_sin       = LO_WIDTH'(s);
        bus.i_valid     = v;
    endtask

    // Back-to-back clipping samples; optional clear alongside the transfer of output clear_at.
    task automatic stream_clip(input int n, input int clear_at);
        bit chk_zero;
        chk_zero = 1'b0;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < n + 50 && rcv < n; cyc++) begin
            bus.i_ready = 1'b1;
            drive(2'b00, 32767, 32767, 92682, 92682, sent < n);
            bus.i_sat_clear = (clear_at >= 0) && (rcv == clear_at) && bus.o_valid;
            #1;
            if (chk_zero) begin
                check("post_clear_count", bus.o_sat_count, 0);
                check("post_clear_flag", bus.o_sat_flag, 0);
                chk_zero = 1'b0;
            end
            if (bus.i_sat_clear) begin
                check("pre_clear_count", bus.o_sat_count, clear_at);
                chk_zero = 1'b1;
            end
            if (bus.o_valid) rcv++;
            if (bus.i_valid && bus.o_ready) sent++;
            tick();
            bus.i_sat_clear = 1'b0;
        end
        bus.i_valid = 1'b0;
        check("stream_drained", rcv, n);
    endtask

    initial begin
        logic signed [WIDTH-1:0] hold_i, hold_q;
        bit holding;

        vt[0]  = '{2'b00,   1000,   -500,  131071,      0,   1000,   -500, 1'b0};
        vt[1]  = '{2'b00,  32767,  32767,   92682,  92682,      0,  32767, 1'b1};
        vt[2]  = '{2'b01,  32767,  32767,   92682,  92682,  32767,      0, 1'b1};
        vt[3]  = '{2'b10, -32768,  12345,    5000,  -7000, -32768,  12345, 1'b0};
        vt[4]  = '{2'b11,      7,     -7,  131071, 131071,      7,     -7, 1'b0};
        vt[5]  = '{2'b00,  16384,      0,       0,  65536,      0,   8192, 1'b0};
        vt[6]  = '{2'b01,  16384,      0,       0,  65536,      0,  -8192, 1'b0};
        vt[7]  = '{2'b00, -32768,  32767,   92682,  92682, -32768,     -1, 1'b1};
        vt[8]  = '{2'b00,      1,      0,   65536,      0,      1,      0, 1'b0};
        vt[9]  = '{2'b00,     -1,      0,   65536,      0,      0,      0, 1'b0};
        vt[10] = '{2'b00, -32768,      0, -131072,      0,  32767,      0, 1'b1};
        vt[11] = '{2'b01,      3,     -5, -131072,-131072,      2,      8, 1'b0};

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst      = 1'b0;
        bus.i_ready     = 1'b1;
        bus.i_sat_clear = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b0);

        // Asynchronous reset, before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_count", bus.o_sat_count, 0);
        check("rst_flag", bus.o_sat_flag, 0);
        check("rst_inph", bus.o_inph_data, 0);
        check("rst_quad", bus.o_quad_data, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", bus.o_ready, 1);

        // Table of single samples, each checked at the 4-cycle latency point
        for (int k = 0; k < 12; k++) begin
            drive(vt[k].mode, vt[k].i, vt[k].q, vt[k].c, vt[k].s, 1'b1);
            tick();
            bus.i_valid = 1'b0;
            tick();
            tick();
            check($sformatf("vec%0d_early_valid", k), bus.o_valid, 0);
            tick();
            check($sformatf("vec%0d_valid", k), bus.o_valid, 1);
            check($sformatf("vec%0d_inph", k), bus.o_inph_data, vt[k].ei);
            check($sformatf("vec%0d_quad", k), bus.o_quad_data, vt[k].eq);
            check($sformatf("vec%0d_count", k), bus.o_sat_count, exp_cnt);
            check($sformatf("vec%0d_flag", k), bus.o_sat_flag, exp_cnt != 0);
            if (vt[k].sat) exp_cnt++;
        end
        tick();
        check("table_count", bus.o_sat_count, exp_cnt);

        // Ten samples with downstream stalled in cycles 3..8
        sent    = 0;
        rcv     = 0;
        holding = 1'b0;
        hold_i  = '0;
        hold_q  = '0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            bus.i_ready = !(cyc >= 3 && cyc <= 8);
            if (sent < 10) drive(2'b00, 100 * sent + 3, -(50 * sent + 7), 131071, 0, 1'b1);
            else bus.i_valid = 1'b0;
            #1;
            if (bus.o_valid && !bus.i_ready) begin
                check("stall_ready", bus.o_ready, 0);
                if (holding) begin
                    check("stall_hold_inph", bus.o_inph_data, hold_i);
                    check("stall_hold_quad", bus.o_quad_data, hold_q);
                end
                hold_i  = bus.o_inph_data;
                hold_q  = bus.o_quad_data;
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (bus.o_valid && bus.i_ready) begin
                check($sformatf("stall_out%0d_inph", rcv), bus.o_inph_data, 100 * rcv + 3);
                check($sformatf("stall_out%0d_quad", rcv), bus.o_quad_data, -(50 * rcv + 7));
                rcv++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        check("stall_all_out", rcv, 10);
        check("stall_no_extra", bus.o_valid, 0);
        check("stall_count", bus.o_sat_count, exp_cnt);

        // Saturation statistics: clear mid-stream, then count ceiling
        bus.i_sat_clear = 1'b1;
        tick();
        bus.i_sat_clear = 1'b0;
        check("clear_count", bus.o_sat_count, 0);
        check("clear_flag", bus.o_sat_flag, 0);
        stream_clip(500, 99);
        check("clip500_count", bus.o_sat_count, 400);
        check("clip500_flag", bus.o_sat_flag, 1);
        stream_clip(65134, -1);
        check("near_max_count", bus.o_sat_count, 65534);
        stream_clip(1, -1);
        check("max_count", bus.o_sat_count, 65535);
        stream_clip(3, -1);
        check("max_hold_count", bus.o_sat_count, 65535);
        check("max_hold_flag", bus.o_sat_flag, 1);
        bus.i_sat_clear = 1'b1;
        tick();
        bus.i_sat_clear = 1'b0;
        check("final_clear_count", bus.o_sat_count, 0);

        // Reset with samples in flight
        for (int k = 0; k < 4; k++) begin
            drive(2'b10, 11 * (k + 1), -3 * (k + 1), 0, 0, 1'b1);
            tick();
        end
        bus.i_valid = 1'b0;
        check("midrst_pre_valid", bus.o_valid, 1);
        check("midrst_pre_inph", bus.o_inph_data, 11);
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_inph", bus.o_inph_data, 0);
        check("midrst_quad", bus.o_quad_data, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_ready", bus.o_ready, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("midrst_quiet%0d", k), bus.o_valid, 0);
        end
        drive(2'b00, 1000, -500, 131071, 0, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        check("post_rst_early_valid", bus.o_valid, 0);
        tick();
        check("post_rst_valid", bus.o_valid, 1);
        check("post_rst_inph", bus.o_inph_data, 1000);
        check("post_rst_quad", bus.o_quad_data, -500);
        check("post_rst_count", bus.o_sat_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/duc_mixer_stream.md
DUC_MIXER_STREAM -- requirements
Module: duc_mixer_stream

Interface
REQ-001 Parameter WIDTH, default 16: signed I/Q sample width, input and output.
REQ-002 Parameter LO_WIDTH, default 18: signed cosine/sine width, Q1.(LO_WIDTH-1) format.
REQ-003 Parameter GAIN_SHIFT, default 1: extra output gain of 2^GAIN_SHIFT; legal values 0 or 1.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_inph_data  in  WIDTH  signed input I sample.
- i_quad_data  in  WIDTH  signed input Q sample.
- i_cos  in  LO_WIDTH  signed LO cosine, paired with the sample.
- i_sin  in  LO_WIDTH  signed LO sine, paired with the sample.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept an input.
- i_mode  in  2  00 = multiply by e^{+jθ}; 01 = multiply by e^{-jθ}; 10 and 11 = bypass.
- i_sat_clear  in  1  synchronous clear of the saturation statistics.
- o_inph_data  out  WIDTH  signed output I sample.
- o_quad_data  out  WIDTH  signed output Q sample.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- o_sat_count  out  16  count of saturated output samples.
- o_sat_flag  out  1  sticky saturation flag.

Function
REQ-005 The block SHALL be a 4-stage pipeline with a valid bit per stage: register, multiply, add, round/saturate.
REQ-006 The pipeline SHALL advance when adv = !o_valid || i_ready; all stages hold when adv = 0.
REQ-007 o_ready SHALL equal adv; an input transfer is i_valid && o_ready.
REQ-008 With no backpressure, the output SHALL appear exactly 4 cycles after acceptance. Throughput SHALL be one sample per cycle. Bubbles SHALL propagate as invalid stages.
REQ-009 The block SHALL capture i_mode together with each accepted sample. A mode change SHALL apply from the next accepted sample, with no corruption of in-flight samples.
REQ-010 Mode 00 SHALL compute I' = I*cos - Q*sin and Q' = Q*cos + I*sin.
REQ-011 Mode 01 SHALL compute I' = I*cos + Q*sin and Q' = Q*cos - I*sin.
REQ-012 Products SHALL be full precision at WIDTH+LO_WIDTH bits. Sums SHALL be WIDTH+LO_WIDTH+1 bits, with no intermediate overflow.
REQ-013 Scaling: with S = LO_WIDTH-1-GAIN_SHIFT, the result SHALL be (sum + 2^(S-1)) arithmetically shifted right by S (round half up).
REQ-014 The block SHALL saturate the rounded result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] independently per rail.
REQ-015 Bypass modes SHALL output the input I/Q unchanged, with the same 4-cycle latency and no saturation event.
REQ-016 A sample is a saturation event if either rail clips; it SHALL count once per sample.
REQ-017 The statistics SHALL update only when the sample is transferred out (o_valid && i_ready).
REQ-018 o_sat_count SHALL increment per event and hold at 65535; it SHALL never wrap.
REQ-019 o_sat_flag SHALL set on the first event and remain set until cleared.
REQ-020 i_sat_clear SHALL zero o_sat_count and o_sat_flag next cycle, taking priority over a simultaneous event.
REQ-021 o_inph_data and o_quad_data SHALL be stable while o_valid && !i_ready.

Reset
REQ-022 While i_reset is high, and immediately on its assertion, the block SHALL clear all stage valids, o_valid, o_sat_count and o_sat_flag to 0.
REQ-023 On reset, o_inph_data, o_quad_data and the data registers SHALL go to 0. o_ready SHALL be 1 once reset is released.
REQ-024 A reset mid-stream SHALL discard all in-flight samples, with no output after release until new input is accepted.

Verification (WIDTH=16, LO_WIDTH=18)
REQ-025 GAIN_SHIFT=0, mode 00, cos=131071, sin=0, I=1000, Q=-500 -> output 4 cycles later is I'=1000, Q'=-500, with o_sat_count=0.
REQ-026 GAIN_SHIFT=0, mode 00, I=Q=32767, cos=sin=92682 -> I'=0, Q'=32767 (clipped), with o_sat_count=1 and o_sat_flag=1. The same input in mode 01 -> I'=32767, Q'=0.
REQ-027 Mode 10 with I=-32768, Q=12345 and any LO -> output -32768/12345 after 4 cycles, with no saturation count.
REQ-028 Stream 10 samples while i_ready is held low for cycles 3..8 -> o_ready=0 while stalled, all 10 outputs appear in order with no loss or duplicate, and held output is stable.
REQ-029 500 back-to-back clipping samples with i_sat_clear pulsed at sample 100 -> count restarts from 0 and ends at 400. Forcing the count to 65535 then one more event -> count stays 65535.
REQ-030 Assert i_reset with 3 samples in flight -> o_valid=0 immediately and no output after release. A subsequent sample emerges 4 cycles after acceptance.
